hazard_irq_ctrl: RTL and testbench
==================================

// Module: hazard_irq_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline: generates stall and flush controls for the PC,
//  IF/ID and ID/EX registers. Detects load-use hazards, applies taken-branch and jump flushes,
//  and schedules acceptance of the external interrupt so it enters only at a clean ID boundary.
//  Sits beside Control in ID; replaces the ad-hoc stall flop and IF_Flush logic in the CPU top.
// PARAMETERS
//  LOAD_USE_CYCLES  1  bubbles inserted per load-use hazard (1..3)
//  IRQ_HOLDOFF      0  extra cycles after leaving kernel mode before another IRQ may be taken
// PORTS
//  clk          in   1  pipeline clock (divided clock)
//  reset        in   1  synchronous, active-high
//  MemRead_EX   in   1  instruction in EX is a load
//  RegWrAddr_EX in   5  destination register of the EX instruction
//  RsAddr_ID    in   5  rs field of the ID instruction
//  RtAddr_ID    in   5  rt field of the ID instruction
//  UseRs_ID     in   1  ID instruction reads rs
//  UseRt_ID     in   1  ID instruction reads rt
//  Branch_EX    in   1  branch in EX resolved taken
//  Jump_ID      in   1  j/jal/jr/jalr decoded in ID
//  PC31_ID      in   1  ID instruction runs in kernel mode
//  IRQ          in   1  level interrupt request, same clock domain
//  Stall        out  1  hold PC and IF/ID; inject bubble into ID/EX
//  IF_Flush     out  1  zero IF/ID on next edge
//  ID_Flush     out  1  zero ID/EX on next edge
//  IRQ_Take     out  1  to Control: redirect PC to ILLOP vector, EPC <- PC_ID (PC4_ID-4)
// BEHAVIOUR
//  Reset: state IDLE, bubble counter 0, holdoff counter 0; all outputs 0 in the same cycle.
//  Hazard (comb.): hz = MemRead_EX && RegWrAddr_EX!=0 &&
//    ((UseRs_ID && RsAddr_ID==RegWrAddr_EX) || (UseRt_ID && RtAddr_ID==RegWrAddr_EX)).
//  FSM states: IDLE, STALL, IRQ_PEND, HOLDOFF.
//  Per-cycle priority (highest first):
//    1 Branch_EX: IF_Flush=1, ID_Flush=1, Stall=0; aborts STALL (counter cleared -> IDLE);
//      an IRQ remains pending (IRQ_PEND kept or entered).
//    2 IRQ_Take: when IRQ (or IRQ_PEND) && !PC31_ID && state not STALL/HOLDOFF && !Branch_EX.
//      IRQ_Take=1, IF_Flush=1, ID_Flush=1 for exactly one cycle; next state HOLDOFF if
//      IRQ_HOLDOFF>0 else IDLE.
//    3 hz in IDLE/IRQ_PEND: Stall=1, ID_Flush=1, load counter LOAD_USE_CYCLES-1;
//      stay in STALL while counter!=0 (decrement each cycle), Stall=ID_Flush=1 throughout;
//      counter==0 -> back to IDLE or IRQ_PEND (pending IRQ preserved).
//    4 Jump_ID: IF_Flush=1 only.
//  IRQ arriving while blocked (kernel, stall, branch) -> IRQ_PEND; pending clears only on take.
//  HOLDOFF: counts IRQ_HOLDOFF cycles once PC31_ID==0; IRQ ignored until count expires.
//  Stall and IRQ_Take never both 1. Latency: hz -> Stall same cycle (comb.); IRQ -> IRQ_Take
//    same cycle when unblocked.
//  Synchronous reset mid-STALL or mid-HOLDOFF: next cycle IDLE, outputs 0, pending IRQ dropped.
// STRUCTURE
//  Shared package cpu_pkg: state encodings (2-bit), REG_ZERO=5'd0, ILLOP/XADR vector constants
//  (already used by Control). One natural sub-module: load_use_detect (pure comb. hz compare).
//  FSM and counters in this module; outputs decoded from state + comb. inputs.
// TESTING
//  1 lw $8 in EX, ID reads rs=$8 -> Stall=1, ID_Flush=1 for exactly 1 cycle, then 0.
//  2 LOAD_USE_CYCLES=2, lw $0 vs rs=$0 -> no stall; lw $9 vs rt=$9 -> Stall held 2 cycles.
//  3 Branch_EX=1 during load-use stall -> same cycle Stall=0, IF_Flush=ID_Flush=1; IDLE next.
//  4 IRQ=1 with PC31_ID=1 for 3 cycles, then PC31_ID=0 -> IRQ_Take pulse 1 cycle on 4th cycle.
//  5 IRQ and hz same cycle, PC31_ID=0 -> IRQ_Take=1, Stall=0; IRQ during stall -> taken after.
//  6 reset asserted in STALL with pending IRQ -> all outputs 0 next cycle, no later IRQ_Take.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard/IRQ sequencer state encodings and architectural constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STALL    = 2'd1,
    ST_IRQ_PEND = 2'd2,
    ST_HOLDOFF  = 2'd3
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] ILLOP    = 32'h8000_0004;
  localparam logic [31:0] XADR     = 32'h8000_0008;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX targets a register the ID instruction reads.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       MemRead_EX,
  input  logic [4:0] RegWrAddr_EX,
  input  logic [4:0] RsAddr_ID,
  input  logic [4:0] RtAddr_ID,
  input  logic       UseRs_ID,
  input  logic       UseRt_ID,
  output logic       hz
);

  assign hz = MemRead_EX && (RegWrAddr_EX != REG_ZERO) &&
              ((UseRs_ID && (RsAddr_ID == RegWrAddr_EX)) ||
               (UseRt_ID && (RtAddr_ID == RegWrAddr_EX)));

endmodule

// File: rtl/hazard_irq_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump flushes and interrupt acceptance at an ID boundary.
module hazard_irq_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int IRQ_HOLDOFF     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MemRead_EX,
  input  logic [4:0] RegWrAddr_EX,
  input  logic [4:0] RsAddr_ID,
  input  logic [4:0] RtAddr_ID,
  input  logic       UseRs_ID,
  input  logic       UseRt_ID,
  input  logic       Branch_EX,
  input  logic       Jump_ID,
  input  logic       PC31_ID,
  input  logic       IRQ,
  output logic       Stall,
  output logic       IF_Flush,
  output logic       ID_Flush,
  output logic       IRQ_Take
);

  localparam int              HW        = (IRQ_HOLDOFF > 1) ? $clog2(IRQ_HOLDOFF + 1) : 1;
  localparam logic [1:0]      BUB_LOAD  = 2'(LOAD_USE_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(IRQ_HOLDOFF);

  hz_state_e     state, state_n, ret_state;
  logic [1:0]    bub_cnt, bub_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          pend, pend_n;
  logic          hz, hold_active, irq_in, take;

  load_use_detect u_lud (
    .MemRead_EX   (MemRead_EX),
    .RegWrAddr_EX (RegWrAddr_EX),
    .RsAddr_ID    (RsAddr_ID),
    .RtAddr_ID    (RtAddr_ID),
    .UseRs_ID     (UseRs_ID),
    .UseRt_ID     (UseRt_ID),
    .hz           (hz)
  );

  // While the holdoff window runs, IRQ is neither taken nor remembered.
  assign hold_active = (hold_cnt != '0);
  assign irq_in      = IRQ && !hold_active;
  assign take        = (irq_in || pend) && !PC31_ID && (state != ST_STALL) &&
                       !hold_active && !Branch_EX;

  always_comb begin
    state_n    = state;
    bub_cnt_n  = bub_cnt;
    pend_n     = pend || irq_in;
    hold_cnt_n = (hold_active && !PC31_ID) ? hold_cnt - 1'b1 : hold_cnt;
    Stall      = 1'b0;
    IF_Flush   = 1'b0;
    ID_Flush   = 1'b0;
    IRQ_Take   = 1'b0;
    // State to settle in once nothing more urgent is active.
    ret_state  = pend_n ? ST_IRQ_PEND : ((hold_cnt_n != '0) ? ST_HOLDOFF : ST_IDLE);

    if (reset) begin
      state_n = ST_IDLE;
    end else if (Branch_EX) begin
      IF_Flush  = 1'b1;
      ID_Flush  = 1'b1;
      bub_cnt_n = 2'd0;
      state_n   = ret_state;
    end else if (take) begin
      IRQ_Take   = 1'b1;
      IF_Flush   = 1'b1;
      ID_Flush   = 1'b1;
      pend_n     = 1'b0;
      hold_cnt_n = HOLD_LOAD;
      state_n    = (IRQ_HOLDOFF > 0) ? ST_HOLDOFF : ST_IDLE;
    end else if (state == ST_STALL) begin
      Stall    = 1'b1;
      ID_Flush = 1'b1;
      if (bub_cnt > 2'd1) begin
        bub_cnt_n = bub_cnt - 2'd1;
      end else begin
        bub_cnt_n = 2'd0;
        state_n   = ret_state;
      end
    end else if (hz) begin
      // A hazard during holdoff still stalls; the holdoff count keeps running alongside.
      Stall     = 1'b1;
      ID_Flush  = 1'b1;
      bub_cnt_n = BUB_LOAD;
      state_n   = (BUB_LOAD != 2'd0) ? ST_STALL : ret_state;
    end else begin
      IF_Flush = Jump_ID;
      state_n  = ret_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bub_cnt  <= 2'd0;
      hold_cnt <= '0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      bub_cnt  <= bub_cnt_n;
      hold_cnt <= hold_cnt_n;
      pend     <= pend_n;
    end
  end

endmodule

// File: tb/tb_hazard_irq_ctrl.sv
// Scoreboard bench for hazard_irq_ctrl across three parameterisations sharing one stimulus bus.
module tb_hazard_irq_ctrl;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] wa;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       jmp;
    logic       pc31;
    logic       irq;
    logic [3:0] exp;   // {Stall, IF_Flush, ID_Flush, IRQ_Take}
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, MemRead_EX, UseRs_ID, UseRt_ID, Branch_EX, Jump_ID, PC31_ID, IRQ;
  logic [4:0] RegWrAddr_EX, RsAddr_ID, RtAddr_ID;
  logic [3:0] o1, o2, o3;

  int         n_vec = 0;
  int         n_bad = 0;
  int         sel   = 1;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_irq_ctrl #(.LOAD_USE_CYCLES(1), .IRQ_HOLDOFF(0)) u1 (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RegWrAddr_EX(RegWrAddr_EX),
    .RsAddr_ID(RsAddr_ID), .RtAddr_ID(RtAddr_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .Branch_EX(Branch_EX), .Jump_ID(Jump_ID), .PC31_ID(PC31_ID), .IRQ(IRQ),
    .Stall(o1[3]), .IF_Flush(o1[2]), .ID_Flush(o1[1]), .IRQ_Take(o1[0]));

  hazard_irq_ctrl #(.LOAD_USE_CYCLES(2), .IRQ_HOLDOFF(0)) u2 (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RegWrAddr_EX(RegWrAddr_EX),
    .RsAddr_ID(RsAddr_ID), .RtAddr_ID(RtAddr_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .Branch_EX(Branch_EX), .Jump_ID(Jump_ID), .PC31_ID(PC31_ID), .IRQ(IRQ),
    .Stall(o2[3]), .IF_Flush(o2[2]), .ID_Flush(o2[1]), .IRQ_Take(o2[0]));

  hazard_irq_ctrl #(.LOAD_USE_CYCLES(1), .IRQ_HOLDOFF(2)) u3 (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RegWrAddr_EX(RegWrAddr_EX),
    .RsAddr_ID(RsAddr_ID), .RtAddr_ID(RtAddr_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .Branch_EX(Branch_EX), .Jump_ID(Jump_ID), .PC31_ID(PC31_ID), .IRQ(IRQ),
    .Stall(o3[3]), .IF_Flush(o3[2]), .ID_Flush(o3[1]), .IRQ_Take(o3[0]));

  function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] wa,
                              input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic br, input logic jmp,
                              input logic pc31, input logic irq, input logic [3:0] exp);
    vec_t v;
    v.rst = rst; v.mr = mr; v.wa = wa; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.br = br; v.jmp = jmp; v.pc31 = pc31; v.irq = irq; v.exp = exp;
    return v;
  endfunction

  function automatic logic [3:0] cur_obs();
    case (sel)
      1:       return o1;
      2:       return o2;
      default: return o3;
    endcase
  endfunction

  // Drive one cycle of stimulus just after the edge and queue its expected outputs.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst; MemRead_EX = v.mr; RegWrAddr_EX = v.wa; RsAddr_ID = v.rs; RtAddr_ID = v.rt;
    UseRs_ID = v.urs; UseRt_ID = v.urt; Branch_EX = v.br; Jump_ID = v.jmp;
    PC31_ID = v.pc31; IRQ = v.irq;
    exp_q.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 1;
    tv.push_back(mk(1, 1, 8, 8, 0, 1, 0, 1, 1, 0, 1, 4'b0000)); // everything asserted under reset
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // no IRQ latched during reset
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL reset step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_load_use();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 1;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 4'b1010)); // lw $8, rs=$8
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 8, 0, 8, 0, 0, 0, 0, 0, 0, 4'b0000)); // rt matches but unused
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0100)); // jump
    tv.push_back(mk(0, 0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 4'b0000)); // not a load
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL load_use step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_multi_cycle();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 2;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000)); // lw $0 never stalls
    tv.push_back(mk(0, 1, 9, 0, 9, 0, 1, 0, 0, 0, 0, 4'b1010)); // lw $9, rt=$9
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010)); // second bubble
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL multi_cycle step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_branch_abort();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 2;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 9, 0, 9, 0, 1, 0, 0, 0, 0, 4'b1010));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0110)); // branch kills the stall
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // back in IDLE
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL branch_abort step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_irq_kernel();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 1;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int k = 0; k < 3; k++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0111)); // left kernel mode
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 4'b0110)); // IRQ blocked by branch
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111)); // pending survives branch
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL irq_kernel step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_irq_vs_hazard();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 1;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 1, 4'b0111)); // IRQ beats hazard
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL irq_vs_hz step %0d: got %b want %b", i, g, e); end
    end
    tv.delete();
    sel = 2;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 9, 9, 0, 1, 0, 0, 0, 0, 0, 4'b1010));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1010)); // IRQ inside the stall
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111)); // taken once stall ends
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL irq_in_stall step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_reset_in_stall();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 2;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000)); // IRQ pends in kernel mode
    tv.push_back(mk(0, 1, 9, 9, 0, 1, 0, 0, 0, 1, 0, 4'b1010)); // stall with IRQ pending
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // reset mid-stall
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // pending IRQ dropped
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL reset_in_stall step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_holdoff();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 3;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0111));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000)); // kernel: holdoff not counting
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000)); // holdoff 2 -> 1
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000)); // holdoff 1 -> 0
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0111));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL holdoff step %0d: got %b want %b", i, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv[$];
    logic [3:0] e, g;
    sel = 1;
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    tv.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 4'b1010));
    tv.push_back(mk(0, 1, 7, 0, 7, 0, 1, 0, 0, 0, 0, 4'b1010)); // second hazard right after
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0100));
    tv.push_back(mk(0, 1, 8, 8, 0, 1, 0, 1, 1, 0, 0, 4'b0110)); // branch over hazard and jump
    tv.push_back(mk(0, 1, 8, 8, 0, 1, 0, 0, 1, 0, 0, 4'b1010)); // hazard over jump
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    foreach (tv[i]) begin
      apply(tv[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = cur_obs(); n_vec++;
      if (g !== e) begin n_bad++; $display("FAIL back_to_back step %0d: got %b want %b", i, g, e); end
    end
  endtask

  initial begin
    reset = 1'b1; MemRead_EX = 1'b0; RegWrAddr_EX = 5'd0; RsAddr_ID = 5'd0; RtAddr_ID = 5'd0;
    UseRs_ID = 1'b0; UseRt_ID = 1'b0; Branch_EX = 1'b0; Jump_ID = 1'b0;
    PC31_ID = 1'b0; IRQ = 1'b0;
    test_reset();
    test_load_use();
    test_multi_cycle();
    test_branch_abort();
    test_irq_kernel();
    test_irq_vs_hazard();
    test_reset_in_stall();
    test_holdoff();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
